outputc_alloc: RTL

Per-output-port allocator and credit tracker for the hypercube router. One instance sits on each physical output port. It is the stage directly downstream of the input-channel VC controllers: it consumes their `req` and produces the `grt`, `irdy` and `ilck` signals they wait on. It round-robins among the input ports, holds the granted port until the packet's tail flit, forwards the flits on the link, and counts downstream buffer credits for each output VC.

---
 rtl/outputc_alloc_if.sv | 47 ++++
 rtl/outputc_alloc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/outputc_alloc_if.sv
`default_nettype none
// ============================================================================
// Module   : outputc_alloc_if
// Brief    : Request/grant, flit and credit bundle between the input-port VC
//            controllers, one output-port allocator and the downstream link.
// Revision : 1.0
// ============================================================================
interface outputc_alloc_if #(
    parameter int VCH_NUM       = 4,
    parameter int VCH_WIDTH_NUM = 2,
    parameter int DATA_WIDTH    = 32
);
    logic [4:0]               req;
    logic [VCH_WIDTH_NUM-1:0] ivch_0;
    logic [VCH_WIDTH_NUM-1:0] ivch_1;
    logic [VCH_WIDTH_NUM-1:0] ivch_2;
    logic [VCH_WIDTH_NUM-1:0] ivch_3;
    logic [VCH_WIDTH_NUM-1:0] ivch_4;
    logic [DATA_WIDTH-1:0]    idata_0;
    logic [DATA_WIDTH-1:0]    idata_1;
    logic [DATA_WIDTH-1:0]    idata_2;
    logic [DATA_WIDTH-1:0]    idata_3;
    logic [DATA_WIDTH-1:0]    idata_4;
    logic [4:0]               ivalid;
    logic [VCH_NUM-1:0]       icredit;
    logic [4:0]               grt;
    logic [VCH_NUM-1:0]       irdy;
    logic [VCH_NUM-1:0]       ilck;
    logic [DATA_WIDTH-1:0]    odata;
    logic                     ovalid;
    logic [VCH_WIDTH_NUM-1:0] ovch;

    // Master: the input side plus the downstream credit source.
    modport master (
        output req, ivch_0, ivch_1, ivch_2, ivch_3, ivch_4,
        output idata_0, idata_1, idata_2, idata_3, idata_4, ivalid, icredit,
        input  grt, irdy, ilck, odata, ovalid, ovch
    );

    // Slave: the allocator itself.
    modport slave (
        input  req, ivch_0, ivch_1, ivch_2, ivch_3, ivch_4,
        input  idata_0, idata_1, idata_2, idata_3, idata_4, ivalid, icredit,
        output grt, irdy, ilck, odata, ovalid, ovch
    );
endinterface
`default_nettype wire

// File: rtl/outputc_alloc.sv
`default_nettype none
// ============================================================================
// Module   : outputc_alloc
// Brief    : Per-output-port round-robin allocator, flit forwarder and
//            downstream credit tracker for the hypercube router.
// Revision : 1.0
// ============================================================================
module outputc_alloc #(
    parameter int ROUTERID      = 0,
    parameter int PCHID         = 0,
    parameter int VCH_NUM       = 4,
    parameter int VCH_WIDTH_NUM = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int BUF_DEPTH     = 4
) (
    input  logic           clk,
    input  logic           reset,
    outputc_alloc_if.slave port
);

    localparam int                 c_cnt_w  = $clog2(BUF_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full   = c_cnt_w'(BUF_DEPTH);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
    localparam logic [VCH_NUM-1:0] c_vc_one = VCH_NUM'(1);

    // Flit type lives in the top three bits of every flit.
    localparam logic [2:0] c_type_tail     = 3'd2;
    localparam logic [2:0] c_type_headtail = 3'd3;
    localparam logic [2:0] c_type_test     = 3'd4;
    localparam logic [2:0] c_type_ack      = 3'd5;
    localparam logic [2:0] c_type_ack_back = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    generate
        if (ROUTERID < 0 || PCHID < 0 || PCHID > 4 || VCH_NUM < 1 ||
            VCH_NUM > (1 << VCH_WIDTH_NUM) || BUF_DEPTH < 1) begin : g_param_check
            $error("outputc_alloc: illegal parameter combination");
        end
    endgenerate

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [4:0]               r_grt;
    logic [4:0]               w_grt_nxt;
    logic [VCH_NUM-1:0]       r_ilck;
    logic [VCH_NUM-1:0]       w_ilck_nxt;
    logic [VCH_NUM-1:0]       w_irdy;
    logic [2:0]               r_winner;
    logic [2:0]               w_winner_nxt;
    logic [2:0]               r_ptr;
    logic [2:0]               w_ptr_nxt;
    logic [VCH_WIDTH_NUM-1:0] r_vch;
    logic [VCH_WIDTH_NUM-1:0] w_vch_nxt;
    logic [VCH_WIDTH_NUM-1:0] r_ovch;
    logic [VCH_WIDTH_NUM-1:0] w_ovch_nxt;
    logic [DATA_WIDTH-1:0]    r_odata;
    logic [DATA_WIDTH-1:0]    w_odata_nxt;
    logic                     r_ovalid;
    logic                     w_ovalid_nxt;

    // Padded to 8 entries so any 3-bit port index stays in range.
    logic [VCH_WIDTH_NUM-1:0] w_ivch  [8];
    logic [DATA_WIDTH-1:0]    w_idata [8];
    logic [7:0]               w_ivalid;

    logic [7:0]               w_elig;
    logic                     w_found;
    logic [2:0]               w_win;
    logic [3:0]               w_sum;
    logic [2:0]               w_idx;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic                     w_sel_valid;
    logic [2:0]               w_type;
    logic                     w_fwd;
    logic                     w_last;

    assign w_ivch[0]  = port.ivch_0;
    assign w_ivch[1]  = port.ivch_1;
    assign w_ivch[2]  = port.ivch_2;
    assign w_ivch[3]  = port.ivch_3;
    assign w_ivch[4]  = port.ivch_4;
    assign w_ivch[5]  = '0;
    assign w_ivch[6]  = '0;
    assign w_ivch[7]  = '0;
    assign w_idata[0] = port.idata_0;
    assign w_idata[1] = port.idata_1;
    assign w_idata[2] = port.idata_2;
    assign w_idata[3] = port.idata_3;
    assign w_idata[4] = port.idata_4;
    assign w_idata[5] = '0;
    assign w_idata[6] = '0;
    assign w_idata[7] = '0;
    assign w_ivalid   = {3'b000, port.ivalid};

    // A port may only win a VC that exists, is free and has buffer space.
    always_comb begin
        w_elig = '0;
        for (int p = 0; p < 5; p++) begin
            w_elig[p] = port.req[p] && (32'(w_ivch[p]) < VCH_NUM) &&
                        !r_ilck[w_ivch[p]] && w_irdy[w_ivch[p]];
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo 5.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < 5; k++) begin
            w_sum = {1'b0, r_ptr} + 4'(k);
            w_idx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_sel_data  = w_idata[r_winner];
    assign w_sel_valid = w_ivalid[r_winner];
    assign w_type      = w_sel_data[DATA_WIDTH-1 -: 3];
    assign w_fwd       = (r_state == S_BUSY) && w_sel_valid && w_irdy[r_vch];
    assign w_last      = (w_type == c_type_tail)  || (w_type == c_type_headtail) ||
                         (w_type == c_type_test)  || (w_type == c_type_ack)      ||
                         (w_type == c_type_ack_back);

    always_comb begin
        w_state_nxt  = r_state;
        w_grt_nxt    = r_grt;
        w_ilck_nxt   = r_ilck;
        w_winner_nxt = r_winner;
        w_vch_nxt    = r_vch;
        w_ptr_nxt    = r_ptr;
        w_ovalid_nxt = 1'b0;
        w_odata_nxt  = r_odata;
        w_ovch_nxt   = r_ovch;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = S_BUSY;
                    w_grt_nxt    = 5'b00001 << w_win;
                    w_ilck_nxt   = r_ilck | (c_vc_one << w_ivch[w_win]);
                    w_winner_nxt = w_win;
                    w_vch_nxt    = w_ivch[w_win];
                end
            end
            S_BUSY: begin
                if (w_fwd) begin
                    w_ovalid_nxt = 1'b1;
                    w_odata_nxt  = w_sel_data;
                    w_ovch_nxt   = r_vch;
                    if (w_last) begin
                        // Released winner drops to lowest priority.
                        w_state_nxt = S_IDLE;
                        w_grt_nxt   = '0;
                        w_ilck_nxt  = r_ilck & ~(c_vc_one << r_vch);
                        w_ptr_nxt   = (r_winner == 3'd4) ? 3'd0 : r_winner + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grt    <= '0;
            r_ilck   <= '0;
            r_winner <= '0;
            r_vch    <= '0;
            r_ptr    <= '0;
            r_ovalid <= 1'b0;
            r_odata  <= '0;
            r_ovch   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grt    <= w_grt_nxt;
            r_ilck   <= w_ilck_nxt;
            r_winner <= w_winner_nxt;
            r_vch    <= w_vch_nxt;
            r_ptr    <= w_ptr_nxt;
            r_ovalid <= w_ovalid_nxt;
            r_odata  <= w_odata_nxt;
            r_ovch   <= w_ovch_nxt;
        end
    end

    generate
        for (genvar v = 0; v < VCH_NUM; v++) begin : g_credit
            logic               w_dec;
            logic               w_inc;
            logic [c_cnt_w-1:0] r_cnt;

            assign w_dec = w_fwd && (r_vch == VCH_WIDTH_NUM'(v));
            assign w_inc = port.icredit[v];

            // A return in the same cycle as a send cancels out; a full
            // counter ignores further returns.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= c_full;
                end else if (w_dec && !w_inc) begin
                    r_cnt <= r_cnt - c_one;
                end else if (w_inc && !w_dec && (r_cnt != c_full)) begin
                    r_cnt <= r_cnt + c_one;
                end
            end

            assign w_irdy[v] = (r_cnt != '0);
        end
    endgenerate

    assign port.grt    = r_grt;
    assign port.ilck   = r_ilck;
    assign port.irdy   = w_irdy;
    assign port.odata  = r_odata;
    assign port.ovalid = r_ovalid;
    assign port.ovch   = r_ovch;

endmodule
`default_nettype wire
